// File: rtl/swap_ctrl.sv
// ---------------------------------------------------------------------------
// swap_ctrl
//
// Sequencer for the SISC register-swap instruction (Rs <-> Rt). The register
// file has a single write port, so the swap is spread over several cycles:
//   IDLE -> LATCH -> WR_RT -> WR_RS -> DONE -> IDLE
// LATCH captures both operand values. The two writes then go out in order,
// first Rt <= old Rs and then Rs <= old Rt. When Rs and Rt are the same
// register, LATCH goes straight to DONE and no write is issued.
//
// Optional build macro:
//   SWAP_R0_PROTECT_EN - treats register 0 as hardwired zero. The write
//                        enable is suppressed in any write state whose target
//                        is register 0. The state sequence and timing do not
//                        change.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_f      in   asynchronous active-low reset
//   start      in   swap instruction decoded, sampled only in IDLE
//   rs_addr    in   Rs address from instruction register
//   rt_addr    in   Rt address from instruction register
//   rs_data    in   register file read port A data (reads rd_addr_a)
//   rt_data    in   register file read port B data (reads rd_addr_b)
//   rd_addr_a  out  latched Rs address (read port A, mux Rs input)
//   rd_addr_b  out  latched Rt address (read port B, mux Rt input)
//   swap_sel   out  write-address mux select: 0 = Rt, 1 = Rs
//   rf_we      out  register file write enable
//   wb_data    out  register file write data
//   busy       out  swap in progress (stalls PC and control)
//   done       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module swap_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              swap_sel,
  output logic              rf_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    WR_RT = 3'd2,
    WR_RS = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0]   rd_addr_b_q, rd_addr_b_d;
  logic [DATA_W-1:0]   rs_tmp_q, rs_tmp_d;
  logic [DATA_W-1:0]   rt_tmp_q, rt_tmp_d;
  logic                swap_sel_q, swap_sel_d;
  logic                write_blocked;

  // State register together with the latched addresses, operand temps and
  // mux select. A reset during a swap aborts it at once; any write already
  // committed to the register file stays in place.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= IDLE;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rs_tmp_q    <= '0;
      rt_tmp_q    <= '0;
      swap_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      rs_tmp_q    <= rs_tmp_d;
      rt_tmp_q    <= rt_tmp_d;
      swap_sel_q  <= swap_sel_d;
    end
  end

  // Next-state and register-update logic.
  // The addresses are captured only on the accepting edge. After that the
  // instruction register can change freely. The temps are captured only in
  // LATCH, so the WR_RT write cannot disturb the value that WR_RS writes.
  // swap_sel is set up one edge ahead of each write state, and it holds its
  // value everywhere else.
  always_comb begin
    state_d     = state_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    rs_tmp_d    = rs_tmp_q;
    rt_tmp_d    = rt_tmp_q;
    swap_sel_d  = swap_sel_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_a_d = rs_addr;
          rd_addr_b_d = rt_addr;
          state_d     = LATCH;
        end
      end
      LATCH: begin
        rs_tmp_d = rs_data;
        rt_tmp_d = rt_data;
        if (rd_addr_a_q == rd_addr_b_q) begin
          state_d = DONE;
        end else begin
          state_d    = WR_RT;
          swap_sel_d = 1'b0;
        end
      end
      WR_RT: begin
        state_d    = WR_RS;
        swap_sel_d = 1'b1;
      end
      WR_RS: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register 0 protection: find a write state whose target is register 0.
`ifdef SWAP_R0_PROTECT_EN
  always_comb begin
    write_blocked = 1'b0;
    if (state_q == WR_RT && rd_addr_b_q == '0) begin
      write_blocked = 1'b1;
    end
    if (state_q == WR_RS && rd_addr_a_q == '0) begin
      write_blocked = 1'b1;
    end
  end
`else
  assign write_blocked = 1'b0;
`endif

  // Output decode. Every output comes from registered state only, so there
  // is no combinational path from any input to any output.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rf_we   = 1'b0;
    wb_data = '0;
    unique case (state_q)
      LATCH: begin
        busy = 1'b1;
      end
      WR_RT: begin
        busy    = 1'b1;
        rf_we   = ~write_blocked;
        wb_data = rs_tmp_q;
      end
      WR_RS: begin
        busy    = 1'b1;
        rf_we   = ~write_blocked;
        wb_data = rt_tmp_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign swap_sel  = swap_sel_q;

endmodule

// File: tb/tb_swap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_swap_ctrl
//
// Directed testbench for swap_ctrl. A small 16-entry register file sits
// around the DUT and honours SWAP_R0_PROTECT_EN the same way the real one
// does, with register 0 reading as zero. A bench-side register model predicts
// the writes each swap should produce. Those writes go into a scoreboard
// queue, and the queue is drained whenever the DUT raises rf_we.
// ---------------------------------------------------------------------------
module tb_swap_ctrl;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        sel;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        start;
  logic [3:0]  rsAddr;
  logic [3:0]  rtAddr;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        swap_sel;
  logic        rf_we;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;

  logic        loadEn;
  logic [3:0]  loadAddr;
  logic [31:0] loadData;
  logic [3:0]  wrAddr;

  logic [31:0] rf    [16];
  logic [31:0] expRf [16];
  wr_t         sb    [$];

  int compared   = 0;
  int mismatched = 0;

  swap_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .start     (start),
    .rs_addr   (rsAddr),
    .rt_addr   (rtAddr),
    .rs_data   (rsData),
    .rt_data   (rtData),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .swap_sel  (swap_sel),
    .rf_we     (rf_we),
    .wb_data   (wb_data),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Register file write-address mux that the swap select steers.
  assign wrAddr = swap_sel ? rd_addr_a : rd_addr_b;

  // Combinational read ports. Register 0 reads as zero when the protect
  // build is selected.
  always_comb begin
    rsData = rf[rd_addr_a];
    rtData = rf[rd_addr_b];
`ifdef SWAP_R0_PROTECT_EN
    if (rd_addr_a == 4'd0) rsData = 32'd0;
    if (rd_addr_b == 4'd0) rtData = 32'd0;
`endif
  end

  // Single write port. The bench preloads through it while the DUT is idle.
  always @(posedge clk) begin
    if (loadEn) rf[loadAddr] <= loadData;
    else if (rf_we) rf[wrAddr] <= wb_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain. Each write the DUT issues must match the oldest
  // expected write in address, data and mux select.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checkOutput("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(wrAddr), 32'(e.addr));
        checkOutput("wr_data", wb_data, e.data);
        checkOutput("wr_sel", 32'(swap_sel), 32'(e.sel));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    loadEn   = 1'b1;
    loadAddr = a;
    loadData = d;
    expRf[a] = d;
    step();
    loadEn = 1'b0;
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
`ifdef SWAP_R0_PROTECT_EN
    if (a == 4'd0) return 32'd0;
`endif
    return expRf[a];
  endfunction

  function automatic bit modelBlocked(input logic [3:0] a);
`ifdef SWAP_R0_PROTECT_EN
    return (a == 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Runs one swap from the IDLE cycle and returns in the IDLE cycle after
  // DONE. holdStart keeps start high the whole time. moveAddr changes the
  // instruction-register addresses right after the swap is accepted.
  task automatic applyStimulus(input logic [3:0] rs, input logic [3:0] rt,
                               input bit holdStart, input bit moveAddr);
    logic [31:0] rsVal, rtVal;
    int lat, expLat;
    rsVal  = modelRead(rs);
    rtVal  = modelRead(rt);
    expLat = (rs == rt) ? 2 : 4;
    if (rs != rt) begin
      if (!modelBlocked(rt)) begin
        sb.push_back('{addr: rt, data: rsVal, sel: 1'b0});
        expRf[rt] = rsVal;
      end
      if (!modelBlocked(rs)) begin
        sb.push_back('{addr: rs, data: rtVal, sel: 1'b1});
        expRf[rs] = rtVal;
      end
    end
    start  = 1'b1;
    rsAddr = rs;
    rtAddr = rt;
    step();
    if (!holdStart) start = 1'b0;
    if (moveAddr) begin
      rsAddr = 4'd9;
      rtAddr = 4'd10;
    end
    checkOutput("busy_latch", 32'(busy), 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    checkOutput("done_latency", 32'(lat), 32'(expLat));
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    checkOutput("rd_addr_a_hold", 32'(rd_addr_a), 32'(rs));
    checkOutput("rd_addr_b_hold", 32'(rd_addr_b), 32'(rt));
    step();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    $display("[TB] swap_ctrl bench start");
    rst_f    = 1'b1;
    start    = 1'b0;
    rsAddr   = 4'd0;
    rtAddr   = 4'd0;
    loadEn   = 1'b0;
    loadAddr = 4'd0;
    loadData = 32'd0;
    #2 rst_f = 1'b0;
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_swap_sel", 32'(swap_sel), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_rd_addr_a", 32'(rd_addr_a), 32'd0);
    checkOutput("rst_rd_addr_b", 32'(rd_addr_b), 32'd0);
    rst_f = 1'b1;

    for (int i = 0; i < 16; i++) preload(4'(i), 32'd0);
    preload(4'd3, 32'h0000_1111);
    preload(4'd7, 32'h0000_2222);
    preload(4'd5, 32'h0000_ABCD);
    preload(4'd1, 32'h0000_00A1);
    preload(4'd2, 32'h0000_00B2);
    preload(4'd4, 32'h0000_00C4);
    preload(4'd6, 32'h0000_0055);

    // Normal swap of R3 and R7.
    applyStimulus(4'd3, 4'd7, 1'b0, 1'b0);
    checkOutput("swap_r3", rf[3], 32'h0000_2222);
    checkOutput("swap_r7", rf[7], 32'h0000_1111);
    checkOutput("swap_sel_holds", 32'(swap_sel), 32'd1);

    // Same register in both operands: no writes and a short latency.
    applyStimulus(4'd5, 4'd5, 1'b0, 1'b0);
    checkOutput("same_r5", rf[5], 32'h0000_ABCD);

    // start held high and addresses moved after accept: exactly one swap.
    applyStimulus(4'd3, 4'd7, 1'b1, 1'b1);
    start = 1'b0;
    step();
    checkOutput("no_requeue_busy", 32'(busy), 32'd0);
    checkOutput("no_requeue_addr", 32'(rd_addr_a), 32'd3);
    checkOutput("hold_r3", rf[3], 32'h0000_1111);
    checkOutput("hold_r7", rf[7], 32'h0000_2222);

    // Back-to-back swaps, the second issued in the IDLE cycle after DONE.
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0);
    applyStimulus(4'd2, 4'd4, 1'b0, 1'b0);
    checkOutput("b2b_r1", rf[1], 32'h0000_00B2);
    checkOutput("b2b_r2", rf[2], 32'h0000_00C4);
    checkOutput("b2b_r4", rf[4], 32'h0000_00A1);

    // Swap involving register 0.
    applyStimulus(4'd0, 4'd6, 1'b0, 1'b0);
    checkOutput("r0_swap_r6", rf[6], 32'd0);
`ifdef SWAP_R0_PROTECT_EN
    checkOutput("r0_swap_r0", modelRead(4'd0), 32'd0);
`else
    checkOutput("r0_swap_r0", rf[0], 32'h0000_0055);
`endif

    // Reset while in WR_RT aborts before any write is committed.
    start  = 1'b1;
    rsAddr = 4'd1;
    rtAddr = 4'd2;
    step();
    start = 1'b0;
    step();
    checkOutput("pre_rst_rf_we", 32'(rf_we), 32'd1);
    rst_f = 1'b0;
    #1;
    checkOutput("mid_rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_wb_data", wb_data, 32'd0);
    step();
    rst_f = 1'b1;
    step();
    step();
    step();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_r1", rf[1], 32'h0000_00B2);
    checkOutput("post_rst_r2", rf[2], 32'h0000_00C4);

    for (int i = 1; i < 16; i++) checkOutput($sformatf("final_r%0d", i), rf[i], expRf[i]);
    checkOutput("writes_all_seen", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/swap_ctrl.md
Name: swap_ctrl

Overview:
Multi-cycle sequencer for the SISC register-swap instruction (Rs <-> Rt) over the register file's single write port. Latches both operand addresses and values, then issues two ordered writes. Drives the swap address mux select (1 -> mux passes Rs address, 0 -> mux passes Rt address). Stalls instruction fetch while busy.

Parameters:
DATA_W, 32, register file data width
ADDR_W, 4, register address width

Ports:
clk  input  1  system clock, rising edge
rst_f  input  1  asynchronous active-low reset
start  input  1  swap instruction decoded; sampled only in IDLE
rs_addr  input  ADDR_W  Rs address from instruction register
rt_addr  input  ADDR_W  Rt address from instruction register
rs_data  input  DATA_W  register file read port A data (combinational read of rd_addr_a)
rt_data  input  DATA_W  register file read port B data (combinational read of rd_addr_b)
rd_addr_a  output  ADDR_W  latched Rs address to read port A and mux Rs input
rd_addr_b  output  ADDR_W  latched Rt address to read port B and mux Rt input
swap_sel  output  1  swap mux select: 0 = write Rt, 1 = write Rs
rf_we  output  1  register file write enable
wb_data  output  DATA_W  register file write data
busy  output  1  swap in progress; stalls PC and control
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_f=0, async): state IDLE; rd_addr_a, rd_addr_b, rs_tmp, rt_tmp, wb_data = 0; swap_sel, rf_we, busy, done = 0. Reset mid-swap aborts immediately; writes already committed are not undone.
- All outputs decode from registered state and registers only; no combinational path from inputs to outputs.
- States:
  - IDLE: busy=0. On edge with start=1: rs_addr -> rd_addr_a, rt_addr -> rd_addr_b; go LATCH.
  - LATCH: busy=1, rf_we=0. On edge: rs_data -> rs_tmp, rt_data -> rt_tmp. If rd_addr_a == rd_addr_b, go DONE (no writes); else go WR_RT.
  - WR_RT: busy=1, swap_sel=0, rf_we=1, wb_data=rs_tmp. Rt written at end of cycle. Go WR_RS.
  - WR_RS: busy=1, swap_sel=1, rf_we=1, wb_data=rt_tmp. Rs written at end of cycle. Go DONE.
  - DONE: busy=0, done=1, rf_we=0. Go IDLE unconditionally.
- Latency: start edge to done high = 4 cycles for a normal swap, 2 cycles for Rs==Rt.
- start outside IDLE (including DONE) is ignored, not queued. Back-to-back swaps: next start accepted in the IDLE cycle after DONE.
- rs_addr/rt_addr changes after the accepting edge have no effect. Temps are sampled only in LATCH, so WR_RT's write cannot corrupt the WR_RS data.
- swap_sel holds its last value in IDLE/LATCH/DONE; the mux output is don't-care while rf_we=0.

Optional Feature:
SWAP_R0_PROTECT_EN
- Defined: register 0 is hardwired zero. rf_we is forced 0 in any write state whose target address (Rt in WR_RT, Rs in WR_RS) is 0. State sequence and timing are unchanged.
- Undefined: register 0 is written like any other register.

Test Plan:
- Reset: rst_f=0 asserted mid-WR_RT -> same cycle rf_we=0, busy=0, done=0; after release, state IDLE and no further writes.
- Normal swap: R3=0x0000_1111, R7=0x0000_2222, start with rs=3, rt=7 -> WR_RT writes 0x1111 to addr 7 (swap_sel=0), WR_RS writes 0x2222 to addr 3 (swap_sel=1); done pulses 4 cycles after start; final R3=0x2222, R7=0x1111.
- Same register: rs=rt=5, R5=0xABCD -> rf_we never high, done at cycle 2, R5 unchanged.
- Ignored start / address hold: start held high through the whole swap, and rs/rt changed to 9/10 after accept -> exactly one swap on 3/7; next swap begins only from IDLE after DONE.
- Back-to-back: swap (1,2) then immediately (2,4) -> final values consistent with sequential execution; second start accepted in the cycle after DONE.
- R0 protect: with SWAP_R0_PROTECT_EN, rs=0, rt=6, R6=0x55 -> R6 becomes 0, R0 write suppressed (rf_we=0 in WR_RS), R0 stays 0. Without the macro, R0=0x55.
